// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage: default reset PC,
// the NOP bubble encoding (same value as the NOP opcode used by decode),
// the fetch FSM state encoding and the PC increment helper.
// ---------------------------------------------------------------------------
package if_stage_pkg;

  localparam int unsigned XLEN = 16;

  localparam logic [XLEN-1:0] DEF_RESET_PC  = 16'h0000;
  localparam logic [XLEN-1:0] DEF_NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } if_state_e;

  // Word-addressed increment; the 16-bit result wraps FFFF -> 0000.
  function automatic logic [XLEN-1:0] pcIncrement(input logic [XLEN-1:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/if_pc_gen.sv
// ---------------------------------------------------------------------------
// if_pc_gen
// Owns the fetch PC. Priority: redirect target, then increment on an
// accepted fetch, otherwise hold.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_redirect       load i_redirect_pc
//   i_redirect_pc    redirect target
//   i_advance        fetch accepted this cycle, step to the next word
//   o_fetch_pc       current fetch PC
//   o_next_pc        value fetch PC takes at the next clock edge
// ---------------------------------------------------------------------------
module if_pc_gen
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_advance,
  output logic [XLEN-1:0] o_fetch_pc,
  output logic [XLEN-1:0] o_next_pc
);

  logic [XLEN-1:0] r_fetchPc;
  logic [XLEN-1:0] w_nextPc;

  // Next-PC mux: a redirect always wins over a same-cycle increment.
  always_comb begin
    w_nextPc = r_fetchPc;
    if (i_redirect) begin
      w_nextPc = i_redirect_pc;
    end else if (i_advance) begin
      w_nextPc = pcIncrement(r_fetchPc);
    end
  end

  // Fetch PC register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetchPc <= RESET_PC;
    end else begin
      r_fetchPc <= w_nextPc;
    end
  end

  assign o_fetch_pc = r_fetchPc;
  assign o_next_pc  = w_nextPc;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Issues one outstanding request at a time to
// instruction memory, delivers {instr, pc, valid} to decode through the
// IF/ID register, parks an instruction that returns during a decode stall
// in a one-entry hold buffer, and drains a request orphaned by a redirect.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_stall          hazard unit: freeze IF/ID
//   i_redirect       EX branch/jump pulse, i_redirect_pc is the target
//   o_imem_req       registered fetch request
//   o_imem_addr      fetch word address, stable while o_imem_req=1
//   i_imem_ack       one-cycle response pulse, i_imem_rdata valid with it
//   o_id_instr       IF/ID instruction (NOP_INSTR when invalid)
//   o_id_pc          IF/ID PC
//   o_id_valid       IF/ID valid
// ---------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_id_instr,
  output logic [XLEN-1:0] o_id_pc,
  output logic            o_id_valid
);

  if_state_e       r_state;
  if_state_e       w_nextState;
  logic            r_imemReq;
  logic [XLEN-1:0] r_imemAddr;
  logic [XLEN-1:0] r_idInstr;
  logic [XLEN-1:0] r_idPc;
  logic            r_idValid;
  logic [XLEN-1:0] r_holdInstr;
  logic [XLEN-1:0] r_holdPc;

  logic [XLEN-1:0] w_idInstrNext;
  logic [XLEN-1:0] w_idPcNext;
  logic            w_idValidNext;
  logic [XLEN-1:0] w_holdInstrNext;
  logic [XLEN-1:0] w_holdPcNext;
  logic [XLEN-1:0] w_fetchPc;
  logic [XLEN-1:0] w_nextPc;
  logic            w_advance;

  // Only an ack for a live fetch moves the PC forward; an ack seen while
  // draining belongs to an abandoned address and is dropped.
  assign w_advance = (r_state == S_FETCH) && i_imem_ack && !i_redirect;

  if_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_advance     (w_advance),
    .o_fetch_pc    (w_fetchPc),
    .o_next_pc     (w_nextPc)
  );

  // Next state, IF/ID and hold-buffer contents. Redirect is applied last
  // so it overrides everything except an in-progress drain, where the
  // outstanding ack must still be absorbed.
  always_comb begin
    w_nextState     = r_state;
    w_idInstrNext   = r_idInstr;
    w_idPcNext      = r_idPc;
    w_idValidNext   = r_idValid;
    w_holdInstrNext = r_holdInstr;
    w_holdPcNext    = r_holdPc;

    case (r_state)
      S_IDLE: begin
        w_nextState = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack && !i_stall) begin
          w_idInstrNext = i_imem_rdata;
          w_idPcNext    = w_fetchPc;
          w_idValidNext = 1'b1;
        end else if (i_imem_ack) begin
          w_holdInstrNext = i_imem_rdata;
          w_holdPcNext    = w_fetchPc;
          w_nextState     = S_HOLD;
        end else if (!i_stall) begin
          w_idInstrNext = NOP_INSTR;
          w_idValidNext = 1'b0;
        end
      end
      S_HOLD: begin
        if (!i_stall) begin
          w_idInstrNext = r_holdInstr;
          w_idPcNext    = r_holdPc;
          w_idValidNext = 1'b1;
          w_nextState   = S_FETCH;
        end
      end
      S_DRAIN: begin
        w_idInstrNext = NOP_INSTR;
        w_idValidNext = 1'b0;
        if (i_imem_ack) begin
          w_nextState = S_FETCH;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase

    if (i_redirect && (r_state != S_DRAIN)) begin
      w_idInstrNext   = NOP_INSTR;
      w_idValidNext   = 1'b0;
      w_holdInstrNext = NOP_INSTR;
      w_holdPcNext    = RESET_PC;
      // A request without its ack yet must not be withdrawn.
      if ((r_state == S_FETCH) && !i_imem_ack) begin
        w_nextState = S_DRAIN;
      end else begin
        w_nextState = S_FETCH;
      end
    end
  end

  // State, request interface, IF/ID and hold registers. While draining the
  // address stays on the stale request; otherwise it tracks the next PC,
  // which only moves after an ack, on a redirect, or while req is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_imemReq   <= 1'b0;
      r_imemAddr  <= RESET_PC;
      r_idInstr   <= NOP_INSTR;
      r_idPc      <= RESET_PC;
      r_idValid   <= 1'b0;
      r_holdInstr <= NOP_INSTR;
      r_holdPc    <= RESET_PC;
    end else begin
      r_state     <= w_nextState;
      r_imemReq   <= (w_nextState == S_FETCH) || (w_nextState == S_DRAIN);
      r_imemAddr  <= (w_nextState == S_DRAIN) ? r_imemAddr : w_nextPc;
      r_idInstr   <= w_idInstrNext;
      r_idPc      <= w_idPcNext;
      r_idValid   <= w_idValidNext;
      r_holdInstr <= w_holdInstrNext;
      r_holdPc    <= w_holdPcNext;
    end
  end

  assign o_imem_req  = r_imemReq;
  assign o_imem_addr = r_imemAddr;
  assign o_id_instr  = r_idInstr;
  assign o_id_pc     = r_idPc;
  assign o_id_valid  = r_idValid;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. A simple memory model answers each request
// with 16'h1000 + address after a programmable number of wait cycles; a
// manual ack path is used around reset. Outputs are sampled on the falling
// edge, inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic        clock;
  logic        resetN;
  logic        stall;
  logic        redirect;
  logic [15:0] redirectPc;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck;
  logic [15:0] imemRdata;
  logic [15:0] idInstr;
  logic [15:0] idPc;
  logic        idValid;

  logic        memAuto;
  int          memLatency;
  int          waitCnt;
  logic        autoAck;
  logic [15:0] autoData;
  logic        manAck;
  logic [15:0] manData;

  int checkCount;
  int failCount;

  if_stage dut (
    .i_clk         (clock),
    .i_rst_n       (resetN),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirectPc),
    .o_imem_req    (imemReq),
    .o_imem_addr   (imemAddr),
    .i_imem_ack    (imemAck),
    .i_imem_rdata  (imemRdata),
    .o_id_instr    (idInstr),
    .o_id_pc       (idPc),
    .o_id_valid    (idValid)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // The memory seen by the DUT is either the automatic model or the values
  // driven by hand from the main sequence.
  assign imemAck   = memAuto ? autoAck  : manAck;
  assign imemRdata = memAuto ? autoData : manData;

  // Memory model: shortly after each rising edge look at the request and
  // decide whether the coming cycle carries the ack. memLatency is the
  // number of wait cycles before the ack (0 = zero-wait).
  initial begin
    autoAck  = 1'b0;
    autoData = 16'h0000;
    waitCnt  = 0;
    forever begin
      @(posedge clock);
      #2;
      if (resetN && imemReq) begin
        if (waitCnt >= memLatency) begin
          autoAck  = 1'b1;
          autoData = 16'h1000 + imemAddr;
          waitCnt  = 0;
        end else begin
          autoAck = 1'b0;
          waitCnt = waitCnt + 1;
        end
      end else begin
        autoAck = 1'b0;
        waitCnt = 0;
      end
    end
  end

  // Drive the hazard/redirect inputs together.
  task automatic applyStimulus(input logic st, input logic rd, input logic [15:0] rdPc);
    stall      = st;
    redirect   = rd;
    redirectPc = rdPc;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount = checkCount + 1;
    if (observed !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Main directed sequence; every step is one falling edge.
  initial begin
    checkCount = 0;
    failCount  = 0;
    resetN     = 1'b0;
    memAuto    = 1'b1;
    memLatency = 0;
    manAck     = 1'b0;
    manData    = 16'h0000;
    applyStimulus(1'b0, 1'b0, 16'h0000);

    repeat (2) @(negedge clock);
    checkOutput("reset req",   {15'd0, imemReq}, 16'd0);
    checkOutput("reset addr",  imemAddr,         16'h0000);
    checkOutput("reset valid", {15'd0, idValid}, 16'd0);
    checkOutput("reset instr", idInstr,          16'h0000);
    checkOutput("reset pc",    idPc,             16'h0000);
    resetN = 1'b1;

    // Zero-wait streaming from address 0.
    @(negedge clock);
    checkOutput("first req",   {15'd0, imemReq}, 16'd1);
    checkOutput("first addr",  imemAddr,         16'h0000);
    checkOutput("first valid", {15'd0, idValid}, 16'd0);
    @(negedge clock);
    checkOutput("s0 instr", idInstr, 16'h1000);
    checkOutput("s0 pc",    idPc,    16'h0000);
    checkOutput("s0 valid", {15'd0, idValid}, 16'd1);
    checkOutput("s0 addr",  imemAddr, 16'h0001);
    @(negedge clock);
    checkOutput("s1 instr", idInstr, 16'h1001);
    checkOutput("s1 pc",    idPc,    16'h0001);
    @(negedge clock);
    checkOutput("s2 instr", idInstr, 16'h1002);
    checkOutput("s2 pc",    idPc,    16'h0002);
    checkOutput("s2 valid", {15'd0, idValid}, 16'd1);

    // Stall for three cycles while the ack for address 5 returns.
    @(negedge clock);
    @(negedge clock);
    checkOutput("pre-stall pc", idPc, 16'h0004);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("hold req",   {15'd0, imemReq}, 16'd0);
      checkOutput("hold pc",    idPc,             16'h0004);
      checkOutput("hold instr", idInstr,          16'h1004);
      checkOutput("hold valid", {15'd0, idValid}, 16'd1);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000);
    @(negedge clock);
    checkOutput("release pc",    idPc,             16'h0005);
    checkOutput("release instr", idInstr,          16'h1005);
    checkOutput("release valid", {15'd0, idValid}, 16'd1);
    checkOutput("release req",   {15'd0, imemReq}, 16'd1);
    checkOutput("release addr",  imemAddr,         16'h0006);
    memLatency = 1;
    @(negedge clock);
    checkOutput("resume pc",    idPc,     16'h0006);
    checkOutput("resume instr", idInstr,  16'h1006);
    checkOutput("req7 addr",    imemAddr, 16'h0007);

    // Two-cycle memory; redirect while address 7 is still outstanding.
    applyStimulus(1'b0, 1'b1, 16'h0040);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("drain req",   {15'd0, imemReq}, 16'd1);
    checkOutput("drain addr",  imemAddr,         16'h0007);
    checkOutput("drain valid", {15'd0, idValid}, 16'd0);
    checkOutput("drain pc",    idPc,             16'h0006);
    @(negedge clock);
    checkOutput("post-drain addr",  imemAddr,         16'h0040);
    checkOutput("post-drain valid", {15'd0, idValid}, 16'd0);
    @(negedge clock);
    checkOutput("wait40 valid", {15'd0, idValid}, 16'd0);
    memLatency = 0;
    @(negedge clock);
    checkOutput("tgt40 pc",    idPc,             16'h0040);
    checkOutput("tgt40 instr", idInstr,          16'h1040);
    checkOutput("tgt40 valid", {15'd0, idValid}, 16'd1);
    checkOutput("req41 addr",  imemAddr,         16'h0041);

    // Redirect, stall and ack in the same cycle: redirect wins.
    applyStimulus(1'b1, 1'b1, 16'h0020);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("rsa valid", {15'd0, idValid}, 16'd0);
    checkOutput("rsa instr", idInstr,          16'h0000);
    checkOutput("rsa pc",    idPc,             16'h0040);
    checkOutput("rsa req",   {15'd0, imemReq}, 16'd1);
    checkOutput("rsa addr",  imemAddr,         16'h0020);
    @(negedge clock);
    checkOutput("tgt20 pc",    idPc,             16'h0020);
    checkOutput("tgt20 instr", idInstr,          16'h1020);
    checkOutput("tgt20 valid", {15'd0, idValid}, 16'd1);

    // PC wrap at 16'hFFFF.
    applyStimulus(1'b0, 1'b1, 16'hFFFF);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("wrap req addr", imemAddr,         16'hFFFF);
    checkOutput("wrap pre valid", {15'd0, idValid}, 16'd0);
    @(negedge clock);
    checkOutput("wrap pc",    idPc,     16'hFFFF);
    checkOutput("wrap instr", idInstr,  16'h0FFF);
    checkOutput("wrap addr",  imemAddr, 16'h0000);
    @(negedge clock);
    checkOutput("after wrap pc",    idPc,             16'h0000);
    checkOutput("after wrap instr", idInstr,          16'h1000);
    checkOutput("after wrap req",   {15'd0, imemReq}, 16'd1);
    checkOutput("after wrap addr",  imemAddr,         16'h0001);

    // Asynchronous reset in the middle of a request with no ack.
    manAck  = 1'b0;
    memAuto = 1'b0;
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("async req",   {15'd0, imemReq}, 16'd0);
    checkOutput("async valid", {15'd0, idValid}, 16'd0);
    checkOutput("async addr",  imemAddr,         16'h0000);
    checkOutput("async pc",    idPc,             16'h0000);
    @(negedge clock);
    manAck  = 1'b1;
    manData = 16'hBEEF;
    resetN  = 1'b1;
    @(negedge clock);
    checkOutput("restart req",   {15'd0, imemReq}, 16'd1);
    checkOutput("restart addr",  imemAddr,         16'h0000);
    checkOutput("late ack valid", {15'd0, idValid}, 16'd0);
    checkOutput("late ack instr", idInstr,          16'h0000);
    manAck  = 1'b1;
    manData = 16'h1000;
    @(negedge clock);
    manAck = 1'b0;
    checkOutput("restart pc",    idPc,             16'h0000);
    checkOutput("restart instr", idInstr,          16'h1000);
    checkOutput("restart valid", {15'd0, idValid}, 16'd1);
    checkOutput("restart next",  imemAddr,         16'h0001);

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage 16-bit pipeline, directly upstream of the decode stage. It owns the fetch PC and drives a single-outstanding-request handshake to instruction memory. It delivers {instruction, PC, valid} to decode through the IF/ID register, and honours hazard-unit stalls and branch/jump redirects from EX. A one-entry hold buffer keeps any instruction that returns while decode is stalled.

Parameters:
RESET_PC, 16'h0000, first fetch address after reset
NOP_INSTR, 16'h0000, bubble encoding driven on id_instr when invalid (matches the NOP opcode in def_opcode.v)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hazard unit: hold IF/ID contents, no new instruction may enter decode
redirect  in  1  EX: branch taken or jump; single-cycle pulse
redirect_pc  in  16  target address, valid with redirect
imem_req  out  1  fetch request, registered
imem_addr  out  16  word address of fetch, stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle
imem_rdata  in  16  fetched instruction
id_instr  out  16  IF/ID instruction register
id_pc  out  16  IF/ID PC register
id_valid  out  1  IF/ID valid

Behaviour:
- Reset (rst=0, async): state=S_IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, id_instr=NOP_INSTR, id_pc=RESET_PC, id_valid=0, hold buffer empty. Asserting reset mid-handshake drops imem_req immediately and discards any in-flight response.
- PC arithmetic: word addressed, next = fetch_pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
- States:
  - S_IDLE: entered only from reset. Goes to S_FETCH on the next clock edge, so the first imem_req appears one cycle after reset release.
  - S_FETCH: imem_req=1, imem_addr=fetch_pc.
    - ack, no stall: IF/ID <= {rdata, fetch_pc, 1}; fetch_pc += 1; stay in S_FETCH. Back-to-back fetch gives 1 instruction/cycle with zero-wait memory.
    - ack, stall: hold <= {rdata, fetch_pc}; fetch_pc += 1; go to S_HOLD.
    - no ack, no stall: id_valid <= 0 and id_instr <= NOP_INSTR (bubble).
    - no ack, stall: IF/ID unchanged.
  - S_HOLD: imem_req=0.
    - stall: IF/ID and hold unchanged.
    - stall released: IF/ID <= {hold, 1}; go to S_FETCH.
  - S_DRAIN: imem_req=1, imem_addr keeps the stale address until ack. The ack's data is dropped, then go to S_FETCH. IF/ID stays invalid.
- Redirect has highest priority in every state, stall included:
  - fetch_pc <= redirect_pc.
  - IF/ID <= {NOP_INSTR, id_pc unchanged, 0}.
  - Hold buffer cleared.
  - In S_FETCH with no ack in the same cycle, go to S_DRAIN; a pending request is never withdrawn. Otherwise (ack in the same cycle, S_HOLD, S_IDLE) go to S_FETCH, and a same-cycle ack's data is dropped.
  - A redirect arriving during S_DRAIN only updates fetch_pc; the outstanding ack is still drained.
- imem_addr changes only when imem_req=0 or in the cycle following an ack.
- id_pc is the address of id_instr whenever id_valid=1.

Decomposition:
- Shared package / def_opcode.v: NOP_INSTR encoding and the FSM state encoding (S_IDLE, S_FETCH, S_HOLD, S_DRAIN, 2 bits).
- One natural sub-module, if_pc_gen: holds fetch_pc and implements the redirect / increment / hold mux with the wrap rule.
- The FSM, hold buffer and IF/ID register stay in if_stage.

Test Plan:
- Reset then zero-wait memory returning mem[a]=16'h1000+a → first imem_req the cycle after reset release; id_instr = 1000, 1001, 1002 with id_pc = 0, 1, 2 on consecutive cycles, id_valid=1.
- Stall asserted for 3 cycles while ack returns addr 5 (data 1005) → IF/ID holds addr 4; state S_HOLD with imem_req=0; on release id_pc=5, id_instr=1005, then fetch resumes at 6 with no duplicate and no loss.
- Memory with 2-cycle latency, redirect to 16'h0040 one cycle after requesting addr 7 → S_DRAIN; data for 7 never reaches id_valid=1; next imem_addr=0040 and id_pc=0040 follows.
- Redirect to 16'h0020 in the same cycle as stall and ack → redirect wins: id_valid=0, hold empty, next request at 0020.
- fetch_pc=16'hFFFF, ack → id_pc=FFFF, next imem_addr=0000.
- Async reset asserted mid-request (imem_req=1, no ack) → imem_req=0 and id_valid=0 without waiting for a clock edge; a late ack is ignored; after release fetch restarts at RESET_PC.
